// File: rtl/exa_crosb_pkg.sv
// Shared types, default parameters and index helpers for the crossbar input scheduler.
package exa_crosb_pkg;

  localparam int PRIO_NUM_DEF      = 2;
  localparam int VC_NUM_DEF        = 2;
  localparam int OUTPUT_NUM_DEF    = 4;
  localparam int CREDIT_MAX_DEF    = 8;
  localparam int MAX_PKT_BEATS_DEF = 8;
  localparam int REQ_TIMEOUT_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } sched_state_e;

  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic int class_idx(input int prio, input int vc, input int vc_num);
    return prio * vc_num + vc;
  endfunction

  function automatic int wrap_inc(input int v, input int n);
    return (v + 32'sd1 >= n) ? 32'sd0 : v + 32'sd1;
  endfunction

endpackage

// File: rtl/exa_crosb_input_vc_scheduler_if.sv
// Queue, arbiter and credit signals of one crossbar input port scheduler.
// master = scheduler side, slave = queue/arbiter/downstream environment side.
interface exa_crosb_input_vc_scheduler_if
  import exa_crosb_pkg::*;
#(
  parameter int prio_num      = PRIO_NUM_DEF,
  parameter int vc_num        = VC_NUM_DEF,
  parameter int output_num    = OUTPUT_NUM_DEF,
  parameter int max_pkt_beats = MAX_PKT_BEATS_DEF
) ();

  localparam int C   = prio_num * vc_num;
  localparam int CSW = idx_width(C);
  localparam int OW  = idx_width(output_num);
  localparam int LW  = $clog2(max_pkt_beats + 1);

  logic [C-1:0]                   i_q_valid;
  logic [C-1:0][OW-1:0]           i_q_dest;
  logic [C-1:0][LW-1:0]           i_q_len;
  logic [output_num-1:0]          i_grant;
  logic                           i_beat_valid;
  logic                           i_last;
  logic [output_num-1:0][C-1:0]   i_credit_ret;
  logic [output_num-1:0][C-1:0]   o_request;
  logic                           o_cts;
  logic [CSW-1:0]                 o_q_sel;
  logic [OW-1:0]                  o_out_sel;
  logic                           o_pop;
  logic                           o_credit_err;

  modport master (
    input  i_q_valid, i_q_dest, i_q_len, i_grant, i_beat_valid, i_last, i_credit_ret,
    output o_request, o_cts, o_q_sel, o_out_sel, o_pop, o_credit_err
  );

  modport slave (
    output i_q_valid, i_q_dest, i_q_len, i_grant, i_beat_valid, i_last, i_credit_ret,
    input  o_request, o_cts, o_q_sel, o_out_sel, o_pop, o_credit_err
  );

endinterface

// File: rtl/exa_crosb_prio_rr_pick.sv
// Combinational selector: highest priority level with any eligible class wins,
// then round-robin over that level's VCs starting at its pointer.
module exa_crosb_prio_rr_pick
  import exa_crosb_pkg::*;
#(
  parameter  int prio_num = PRIO_NUM_DEF,
  parameter  int vc_num   = VC_NUM_DEF,
  localparam int PW       = idx_width(prio_num),
  localparam int VW       = idx_width(vc_num)
) (
  input  logic [prio_num*vc_num-1:0]  eligible,
  input  logic [prio_num-1:0][VW-1:0] rr_ptr,
  output logic                        valid,
  output logic [PW-1:0]               prio,
  output logic [VW-1:0]               vc
);

  logic          found_s;
  logic [VW-1:0] hit_s;
  int            cand_s;

  // Ascending scan so the highest eligible priority level overwrites lower ones.
  always_comb begin
    valid   = 1'b0;
    prio    = '0;
    vc      = '0;
    found_s = 1'b0;
    hit_s   = '0;
    cand_s  = 32'sd0;
    for (int p = 0; p < prio_num; p++) begin
      found_s = 1'b0;
      hit_s   = '0;
      for (int k = 0; k < vc_num; k++) begin
        cand_s = (int'(rr_ptr[p]) + k) % vc_num;
        if (!found_s && eligible[class_idx(p, cand_s, vc_num)]) begin
          found_s = 1'b1;
          hit_s   = VW'(cand_s);
        end else begin
          found_s = found_s;
        end
      end
      if (found_s) begin
        valid = 1'b1;
        prio  = PW'(p);
        vc    = hit_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/exa_crosb_input_vc_scheduler.sv
// Per-input VC crossbar scheduler: picks a head packet that fits downstream credit,
// requests its output arbiter and sequences the transfer. Option: EXA_IVS_REQ_TIMEOUT_EN.
module exa_crosb_input_vc_scheduler
  import exa_crosb_pkg::*;
#(
  parameter int prio_num      = PRIO_NUM_DEF,
  parameter int vc_num        = VC_NUM_DEF,
  parameter int output_num    = OUTPUT_NUM_DEF,
  parameter int credit_max    = CREDIT_MAX_DEF,
  parameter int max_pkt_beats = MAX_PKT_BEATS_DEF
`ifdef EXA_IVS_REQ_TIMEOUT_EN
  ,
  parameter int req_timeout   = REQ_TIMEOUT_DEF
`endif
) (
  input logic                            clk,
  input logic                            reset,
  exa_crosb_input_vc_scheduler_if.master bus
);

  localparam int C   = prio_num * vc_num;
  localparam int CSW = idx_width(C);
  localparam int OW  = idx_width(output_num);
  localparam int PW  = idx_width(prio_num);
  localparam int VW  = idx_width(vc_num);
  localparam int LW  = $clog2(max_pkt_beats + 1);
  localparam int CW  = $clog2(credit_max + 1);
  localparam int DW  = ((CW > LW) ? CW : LW) + 2;

  sched_state_e                          state_r;
  sched_state_e                          next_state_s;
  logic [CSW-1:0]                        q_sel_r;
  logic [OW-1:0]                         out_sel_r;
  logic [PW-1:0]                         prio_r;
  logic [VW-1:0]                         vc_r;
  logic [output_num-1:0][C-1:0]          request_r;
  logic [output_num-1:0][C-1:0]          request_next_s;
  logic                                  cts_r;
  logic                                  credit_err_r;
  logic [output_num-1:0][C-1:0][CW-1:0]  credit_r;
  logic [output_num-1:0][C-1:0][CW-1:0]  credit_next_s;
  logic [DW-1:0]                         credit_sum_s;
  logic                                  credit_ovf_s;
  logic [prio_num-1:0][VW-1:0]           rr_ptr_r;
  logic [C-1:0]                          eligible_s;
  logic                                  pick_valid_s;
  logic [PW-1:0]                         pick_prio_s;
  logic [VW-1:0]                         pick_vc_s;
  logic [CSW-1:0]                        pick_class_s;
  logic [OW-1:0]                         pick_dest_s;
  logic [LW-1:0]                         pick_len_s;
  logic [VW-1:0]                         next_vc_s;
  logic                                  take_s;
  logic                                  done_s;
  logic                                  timeout_s;

  // A class is eligible only when its whole packet fits the downstream credit.
  always_comb begin
    eligible_s = '0;
    for (int c = 0; c < C; c++) begin
      eligible_s[c] = bus.i_q_valid[c] &
                      (DW'(credit_r[bus.i_q_dest[c]][c]) >= DW'(bus.i_q_len[c]));
    end
  end

  exa_crosb_prio_rr_pick #(
    .prio_num (prio_num),
    .vc_num   (vc_num)
  ) u_pick (
    .eligible (eligible_s),
    .rr_ptr   (rr_ptr_r),
    .valid    (pick_valid_s),
    .prio     (pick_prio_s),
    .vc       (pick_vc_s)
  );

  assign pick_class_s = CSW'(class_idx(int'(pick_prio_s), int'(pick_vc_s), vc_num));
  assign pick_dest_s  = bus.i_q_dest[pick_class_s];
  assign pick_len_s   = bus.i_q_len[pick_class_s];
  assign next_vc_s    = VW'(wrap_inc(int'(vc_r), vc_num));

`ifdef EXA_IVS_REQ_TIMEOUT_EN
  localparam int TW = ($clog2(req_timeout + 1) > 5) ? $clog2(req_timeout + 1) : 5;

  logic [TW-1:0] wait_cnt_r;
  logic [LW-1:0] len_r;

  // Grant wait counter, restarted on every REQ entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (take_s) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      wait_cnt_r <= wait_cnt_r + TW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Remember the deducted length so an abandoned request can refund it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r <= '0;
    end else if (take_s) begin
      len_r <= pick_len_s;
    end else begin
      len_r <= len_r;
    end
  end

  assign timeout_s = (state_r == ST_REQ) & ~bus.i_grant[out_sel_r] &
                     (wait_cnt_r == TW'(req_timeout - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic for the IDLE/REQ/XFER sequencer.
  always_comb begin
    next_state_s = state_r;
    take_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          next_state_s = ST_REQ;
          take_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.i_grant[out_sel_r]) begin
          next_state_s = ST_XFER;
        end else if (timeout_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_XFER: begin
        if (bus.i_beat_valid & bus.i_last) begin
          next_state_s = ST_IDLE;
          done_s       = 1'b1;
        end else begin
          next_state_s = ST_XFER;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // One-hot request for the class held (or just picked) while in REQ.
  always_comb begin
    request_next_s = '0;
    if (take_s) begin
      request_next_s[pick_dest_s][pick_class_s] = 1'b1;
    end else if (next_state_s == ST_REQ) begin
      request_next_s[out_sel_r][q_sel_r] = 1'b1;
    end else begin
      request_next_s = '0;
    end
  end

  // Net credit update: returns, refund and deduction combine; overflow saturates and flags.
  always_comb begin
    credit_next_s = credit_r;
    credit_ovf_s  = 1'b0;
    credit_sum_s  = '0;
    for (int o = 0; o < output_num; o++) begin
      for (int c = 0; c < C; c++) begin
        credit_sum_s = DW'(credit_r[o][c]) + DW'(bus.i_credit_ret[o][c]);
`ifdef EXA_IVS_REQ_TIMEOUT_EN
        if (timeout_s && (OW'(o) == out_sel_r) && (CSW'(c) == q_sel_r)) begin
          credit_sum_s = credit_sum_s + DW'(len_r);
        end else begin
          credit_sum_s = credit_sum_s;
        end
`endif
        if (take_s && (OW'(o) == pick_dest_s) && (CSW'(c) == pick_class_s)) begin
          credit_sum_s = credit_sum_s - DW'(pick_len_s);
        end else begin
          credit_sum_s = credit_sum_s;
        end
        if (credit_sum_s > DW'(credit_max)) begin
          credit_next_s[o][c] = CW'(credit_max);
          credit_ovf_s        = 1'b1;
        end else begin
          credit_next_s[o][c] = credit_sum_s[CW-1:0];
        end
      end
    end
  end

  // State, registered outputs, credit array and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      request_r    <= '0;
      cts_r        <= 1'b0;
      credit_r     <= {(output_num * C){CW'(credit_max)}};
      credit_err_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      request_r    <= request_next_s;
      cts_r        <= (next_state_s == ST_XFER);
      credit_r     <= credit_next_s;
      credit_err_r <= credit_err_r | credit_ovf_s;
    end
  end

  // Capture the selected class when a packet is committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_sel_r   <= '0;
      out_sel_r <= '0;
      prio_r    <= '0;
      vc_r      <= '0;
    end else if (take_s) begin
      q_sel_r   <= pick_class_s;
      out_sel_r <= pick_dest_s;
      prio_r    <= pick_prio_s;
      vc_r      <= pick_vc_s;
    end else begin
      q_sel_r   <= q_sel_r;
      out_sel_r <= out_sel_r;
      prio_r    <= prio_r;
      vc_r      <= vc_r;
    end
  end

  // Round-robin pointer moves past the served (or abandoned) VC of its level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (done_s | timeout_s) begin
      rr_ptr_r[prio_r] <= next_vc_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign bus.o_request    = request_r;
  assign bus.o_cts        = cts_r;
  assign bus.o_q_sel      = q_sel_r;
  assign bus.o_out_sel    = out_sel_r;
  assign bus.o_pop        = (state_r == ST_XFER) & bus.i_beat_valid;
  assign bus.o_credit_err = credit_err_r;

endmodule

// File: tb/tb_exa_crosb_input_vc_scheduler.sv
// Self-checking bench for exa_crosb_input_vc_scheduler: vector table plus corner sequences.
module tb_exa_crosb_input_vc_scheduler;
  import exa_crosb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exa_crosb_input_vc_scheduler_if bus ();

  exa_crosb_input_vc_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]      valid;
    logic [3:0][1:0] dest;
    logic [3:0][3:0] len;
    int              cls;
    int              edest;
    int              elen;
  } vec_t;

  typedef struct {
    int cls;
    int dest;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[10];

  function automatic vec_t mk(input logic [3:0] v,
                              input logic [1:0] d3, input logic [1:0] d2,
                              input logic [1:0] d1, input logic [1:0] d0,
                              input logic [3:0] l3, input logic [3:0] l2,
                              input logic [3:0] l1, input logic [3:0] l0,
                              input int cls, input int edest, input int elen);
    vec_t r;
    r.valid = v;
    r.dest  = {d3, d2, d1, d0};
    r.len   = {l3, l2, l1, l0};
    r.cls   = cls;
    r.edest = edest;
    r.elen  = elen;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_q_valid    = '0;
    bus.i_q_dest     = '0;
    bus.i_q_len      = '0;
    bus.i_grant      = '0;
    bus.i_beat_valid = 1'b0;
    bus.i_last       = 1'b0;
    bus.i_credit_ret = '0;
  endtask

  // Waits for the request, grants it, moves len beats and optionally returns the credits.
  task automatic run_pkt(input int cls, input int dest, input int len, input bit ret,
                         input string tag);
    logic [3:0][3:0] exp_req;
    sb_t e;
    int  k;
    int  pops;
    bit  cts_ok;
    exp_req = '0;
    exp_req[dest][cls] = 1'b1;
    k = 0;
    while (bus.o_request === '0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({tag, " request"}, 64'(bus.o_request), 64'(exp_req));
    check({tag, " cts_in_req"}, 64'(bus.o_cts), 64'd0);
    sb.push_back('{cls, dest});
    bus.i_q_valid = '0;
    bus.i_grant = '0;
    bus.i_grant[dest] = 1'b1;
    @(negedge clk);
    bus.i_grant = '0;
    check({tag, " cts"}, 64'(bus.o_cts), 64'd1);
    check({tag, " request_drop"}, 64'(bus.o_request), 64'd0);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " q_sel"}, 64'(bus.o_q_sel), 64'(e.cls));
      check({tag, " out_sel"}, 64'(bus.o_out_sel), 64'(e.dest));
    end
    pops = 0;
    cts_ok = 1'b1;
    for (int b = 0; b < len; b++) begin
      bus.i_beat_valid = 1'b1;
      bus.i_last = (b == len - 1);
      #1;
      if (bus.o_pop === 1'b1) pops++;
      if (bus.o_cts !== 1'b1) cts_ok = 1'b0;
      @(negedge clk);
    end
    bus.i_beat_valid = 1'b0;
    bus.i_last = 1'b0;
    #1;
    check({tag, " pops"}, 64'(pops), 64'(len));
    check({tag, " cts_held"}, 64'(cts_ok), 64'd1);
    check({tag, " cts_after"}, 64'(bus.o_cts), 64'd0);
    check({tag, " req_after"}, 64'(bus.o_request), 64'd0);
    if (ret) begin
      @(negedge clk);
      bus.i_credit_ret[dest][cls] = 1'b1;
      repeat (len) @(negedge clk);
      bus.i_credit_ret = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " request"}, 64'(bus.o_request), 64'd0);
    check({tag, " cts"}, 64'(bus.o_cts), 64'd0);
    check({tag, " pop"}, 64'(bus.o_pop), 64'd0);
    check({tag, " q_sel"}, 64'(bus.o_q_sel), 64'd0);
    check({tag, " out_sel"}, 64'(bus.o_out_sel), 64'd0);
    check({tag, " credit_err"}, 64'(bus.o_credit_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][3:0] exp_req;
    bit saw;
    int cnt;

    // Expected picks follow the round-robin history of the preceding rows.
    vecs[0] = mk(4'b0001, 2'd0, 2'd0, 2'd0, 2'd2, 4'd1, 4'd1, 4'd1, 4'd4, 0, 2, 4);
    vecs[1] = mk(4'b0110, 2'd0, 2'd3, 2'd1, 2'd0, 4'd1, 4'd3, 4'd2, 4'd1, 2, 3, 3);
    vecs[2] = mk(4'b0010, 2'd0, 2'd0, 2'd1, 2'd0, 4'd1, 4'd1, 4'd2, 4'd1, 1, 1, 2);
    vecs[3] = mk(4'b1100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd1, 4'd1, 4'd1, 4'd1, 3, 0, 1);
    vecs[4] = mk(4'b1100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd1, 4'd1, 4'd1, 4'd1, 2, 0, 1);
    vecs[5] = mk(4'b1100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd1, 4'd1, 4'd1, 4'd1, 3, 0, 1);
    vecs[6] = mk(4'b0011, 2'd0, 2'd0, 2'd3, 2'd3, 4'd1, 4'd1, 4'd1, 4'd8, 0, 3, 8);
    vecs[7] = mk(4'b0011, 2'd0, 2'd0, 2'd3, 2'd3, 4'd1, 4'd1, 4'd1, 4'd8, 1, 3, 1);
    vecs[8] = mk(4'b1111, 2'd3, 2'd2, 2'd1, 2'd0, 4'd1, 4'd5, 4'd2, 4'd1, 2, 2, 5);
    vecs[9] = mk(4'b1111, 2'd3, 2'd2, 2'd1, 2'd0, 4'd1, 4'd5, 4'd2, 4'd1, 3, 3, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 10; i++) begin
      bus.i_q_valid = vecs[i].valid;
      bus.i_q_dest  = vecs[i].dest;
      bus.i_q_len   = vecs[i].len;
      @(negedge clk);
      run_pkt(vecs[i].cls, vecs[i].edest, vecs[i].elen, 1'b1, $sformatf("vec%0d", i));
    end

    // Grant on a different output and a dropped valid must not disturb REQ.
    bus.i_q_valid = 4'b0010;
    bus.i_q_dest  = {2'd0, 2'd0, 2'd2, 2'd0};
    bus.i_q_len   = {4'd1, 4'd1, 4'd2, 4'd1};
    @(negedge clk);
    bus.i_q_valid = '0;
    bus.i_grant   = 4'b0010;
    repeat (3) @(negedge clk);
    check("other_grant request", 64'(bus.o_request), 64'h0200);
    check("other_grant cts", 64'(bus.o_cts), 64'd0);
    bus.i_grant = '0;
    run_pkt(1, 2, 2, 1'b1, "other_grant");

    // Leave credit[1][0] at 3, then a length-4 packet must wait for one return.
    bus.i_q_valid = 4'b0001;
    bus.i_q_dest  = {2'd0, 2'd0, 2'd0, 2'd1};
    bus.i_q_len   = {4'd1, 4'd1, 4'd1, 4'd5};
    @(negedge clk);
    run_pkt(0, 1, 5, 1'b0, "drain");
    bus.i_q_valid = 4'b0001;
    bus.i_q_len   = {4'd1, 4'd1, 4'd1, 4'd4};
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_request !== '0) saw = 1'b1;
    end
    check("starved request", 64'(saw), 64'd0);
    bus.i_credit_ret[1][0] = 1'b1;
    @(negedge clk);
    bus.i_credit_ret = '0;
    @(negedge clk);
    check("credit_unblock request", 64'(bus.o_request), 64'h0010);
    run_pkt(0, 1, 4, 1'b0, "unblocked");
    bus.i_credit_ret[1][0] = 1'b1;
    repeat (8) @(negedge clk);
    bus.i_credit_ret = '0;
    @(negedge clk);
    check("no_err_balanced", 64'(bus.o_credit_err), 64'd0);

    // Return at full credit: counter holds at the maximum and the error sticks.
    bus.i_credit_ret[0][0] = 1'b1;
    @(negedge clk);
    bus.i_credit_ret = '0;
    check("credit_err set", 64'(bus.o_credit_err), 64'd1);
    repeat (4) @(negedge clk);
    check("credit_err sticky", 64'(bus.o_credit_err), 64'd1);
    bus.i_q_valid = 4'b0001;
    bus.i_q_dest  = '0;
    bus.i_q_len   = {4'd1, 4'd1, 4'd1, 4'd8};
    @(negedge clk);
    run_pkt(0, 0, 8, 1'b1, "full_after_err");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("credit_err cleared", 64'(bus.o_credit_err), 64'd0);

`ifdef EXA_IVS_REQ_TIMEOUT_EN
    // Ungranted class 2 times out, is refunded, and class 3 gets its turn.
    bus.i_q_valid = 4'b1100;
    bus.i_q_dest  = {2'd1, 2'd0, 2'd0, 2'd0};
    bus.i_q_len   = {4'd3, 4'd8, 4'd1, 4'd1};
    @(negedge clk);
    exp_req = '0;
    exp_req[0][2] = 1'b1;
    check("timeout first request", 64'(bus.o_request), 64'(exp_req));
    cnt = 0;
    while (bus.o_request === exp_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout req cycles", 64'(cnt), 64'd16);
    run_pkt(3, 1, 3, 1'b1, "timeout_other");
    bus.i_q_valid = 4'b0100;
    @(negedge clk);
    run_pkt(2, 0, 8, 1'b1, "timeout_refund");
`else
    exp_req = '0;
    cnt = 0;
`endif

    idle_inputs();
    repeat (2) @(negedge clk);
    check("final idle request", 64'(bus.o_request), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exa_crosb_input_vc_scheduler.md
Name: exa_crosb_input_vc_scheduler

Overview:
Per-input-port scheduler for the VC crossbar. It picks one packet at a time from the port's prio_num*vc_num head-of-queue slots, requests the destination output arbiter for that (prio,vc) class, and sequences the transfer until last beat. Tracks downstream per-(output,class) packet-beat credits so only packets that fit are requested. It drives the cts seen by the output arbiter.

Parameters:
prio_num, 2, number of priority levels (max 8)
vc_num, 2, VCs per priority; class index c = prio*vc_num + vc, C = prio_num*vc_num
output_num, 4, crossbar outputs
credit_max, 8, downstream buffer depth in beats per (output,class)
max_pkt_beats, 8, longest packet in beats
req_timeout, 16, cycles REQ may wait for grant (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
i_q_valid  in  C  head-of-queue packet present per class
i_q_dest  in  [C][clog2(output_num)]  destination output of head packet per class
i_q_len  in  [C][clog2(max_pkt_beats+1)]  head packet length in beats, 1..max_pkt_beats
i_grant  in  output_num  grant bit for this input from each output arbiter
i_beat_valid  in  1  one beat forwarded through crossbar this cycle
i_last  in  1  qualifies i_beat_valid as final beat
i_credit_ret  in  [output_num][C]  one-beat credit return pulses
o_request  out  [output_num][C]  one-hot request to output arbiters
o_cts  out  1  clear-to-send to selected output arbiter
o_q_sel  out  clog2(C)  selected class
o_out_sel  out  clog2(output_num)  selected output
o_pop  out  1  dequeue one beat from o_q_sel
o_credit_err  out  1  sticky: credit return would exceed credit_max

Behaviour:
- Reset: state IDLE; o_request=0, o_cts=0, o_pop=0, o_q_sel=0, o_out_sel=0, o_credit_err=0; all credits=credit_max; RR pointers=0. Reset mid-packet abandons the packet; no credit restore beyond credit_max.
- Eligible(c) = i_q_valid[c] & credit[i_q_dest[c]][c] >= i_q_len[c].
- FSM IDLE/REQ/XFER.
- IDLE: highest prio with any eligible class wins; within it, round-robin over vc starting at that prio's pointer. If found: register o_q_sel/o_out_sel, deduct i_q_len from that credit, -> REQ. Else stay.
- REQ: o_request[o_out_sel][o_q_sel]=1 (registered, from first REQ cycle). i_grant[o_out_sel]=1 -> XFER next cycle. Grants on other outputs ignored.
- XFER: o_request=0; o_cts=1 continuously; o_pop=i_beat_valid. i_beat_valid & i_last -> IDLE; that prio's RR pointer = selected vc+1 (wrap to 0). At least one IDLE cycle between packets.
- Credits: counters width clog2(credit_max+1). Deduct and return in same cycle for same counter: net value applied. Return at credit_max: counter holds, o_credit_err set until reset.
- i_q_valid dropping during REQ/XFER: ignored; packet committed.
- o_cts low outside XFER, so an output arbiter that granted without an XFER entry releases.

Optional Feature:
EXA_IVS_REQ_TIMEOUT_EN: defined -> 5-bit-min wait counter cleared on REQ entry; after req_timeout cycles without grant, return to IDLE, refund deducted credits, advance that prio's RR pointer past the class (lets higher prio or other outputs proceed). Undefined -> REQ waits indefinitely; no counter logic.

Decomposition:
- Package exa_crosb_pkg: class-index helper (prio,vc)->c, state enum IDLE/REQ/XFER, width localparams.
- Sub-module exa_crosb_prio_rr_pick: combinational prio-then-RR selector taking eligible vector and pointers, returning valid/prio/vc. Credit array and FSM stay in top.

Test Plan:
- Reset, class 0 valid dest 2 len 4 -> IDLE->REQ; o_request[2][0]=1; grant[2] -> o_cts=1 next cycle; 4 beats with last on 4th -> o_pop 4 cycles, credit[2][0]=4, IDLE.
- Classes 1 (prio0) and 2 (prio1) eligible together -> class 2 selected first, class 1 next.
- Prio1 classes 2,3 continuously eligible, same dest -> alternate 2,3,2,3.
- credit[1][0]=3, len 4 -> no request; one i_credit_ret[1][0] pulse -> request next IDLE cycle.
- Return pulse with credit[0][0]=8 -> holds 8, o_credit_err=1 until reset.
- With EXA_IVS_REQ_TIMEOUT_EN, no grant for 16 cycles -> IDLE, credit refunded, other class requested.
